// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS sequencer driving datapath enables and mux selects
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic [1:0] pc_src_o,
  output logic       ior_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [2:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, ALU_WB = 4'd7,
    BRANCH = 4'd8, I_EXEC = 4'd9, JUMP = 4'd10, JR = 4'd11,
    LUI_WB = 4'd12, ILLEGAL = 4'd13
  } state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q;
  logic       waiting;
  // next state and wait counter; the counter restarts whenever the memory is not being waited on
  always_comb begin
    waiting = (state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE) && !mem_ready_i;
    cnt_d   = waiting ? cnt_q + 8'd1 : 8'd0;
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready_i ? DECODE : FETCH;
      DECODE:
        case (opcode_i)
          6'd35, 6'd43:                    state_d = MEM_ADDR;
          6'd0:                            state_d = (funct_i == 6'd8) ? JR : R_EXEC;
          6'd4, 6'd5:                      state_d = BRANCH;
          6'd8, 6'd10, 6'd12, 6'd13, 6'd14: state_d = I_EXEC;
          6'd15:                           state_d = LUI_WB;
          6'd2, 6'd3:                      state_d = JUMP;
          default:                         state_d = ILLEGAL;
        endcase
      MEM_ADDR:  state_d = (opcode_i == 6'd35) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = mem_ready_i ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready_i ? FETCH : MEM_WRITE;
      R_EXEC, I_EXEC: state_d = ALU_WB;
      MEM_WB, ALU_WB, BRANCH, JUMP, JR, LUI_WB: state_d = FETCH;
      default:   state_d = ILLEGAL;
    endcase
    if (waiting && cnt_d == 8'(MEM_TIMEOUT)) state_d = ILLEGAL;
  end
  // state, wait counter and sticky illegal flag
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= FETCH;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_q | (state_d == ILLEGAL);
    end
  end
  // Moore decode of the current state; everything is held low while reset is asserted
  always_comb begin
    pc_write_o   = 1'b0;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    pc_src_o     = 2'd0;
    ior_d_o      = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'd0;
    mem_to_reg_o = 2'd0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 3'd0;
    alu_op_o     = 3'd0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    if (!reset_i) begin
      instr_done_o = state_q != FETCH && state_d == FETCH;
      illegal_o    = illegal_q;
      case (state_q)
        FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 3'd1;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE:   alu_src_b_o = 3'd3;
        MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 3'd2;
        end
        MEM_READ: begin
          mem_read_o = 1'b1;
          ior_d_o    = 1'b1;
        end
        MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'd1;
        end
        MEM_WRITE: begin
          mem_write_o = 1'b1;
          ior_d_o     = 1'b1;
        end
        R_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'd2;
        end
        I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = (opcode_i == 6'd8 || opcode_i == 6'd10) ? 3'd2 : 3'd4;
          alu_op_o    = opcode_i == 6'd10 ? 3'd6 :
                        opcode_i == 6'd12 ? 3'd4 :
                        opcode_i == 6'd13 ? 3'd3 :
                        opcode_i == 6'd14 ? 3'd5 : 3'd0;
        end
        ALU_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = (opcode_i == 6'd0) ? 2'd1 : 2'd0;
        end
        BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'd1;
          pc_src_o    = 2'd1;
          branch_eq_o = opcode_i == 6'd4;
          branch_ne_o = opcode_i == 6'd5;
        end
        JUMP: begin
          pc_src_o     = 2'd2;
          pc_write_o   = 1'b1;
          reg_write_o  = opcode_i == 6'd3;
          reg_dst_o    = (opcode_i == 6'd3) ? 2'd2 : 2'd0;
          mem_to_reg_o = (opcode_i == 6'd3) ? 2'd2 : 2'd0;
        end
        JR: begin
          pc_src_o   = 2'd3;
          pc_write_o = 1'b1;
        end
        LUI_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'd3;
        end
        default: ;
      endcase
    end
  end
  assign state_o = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the multi-cycle sequencer control word
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_write, branch_eq, branch_ne, ior_d, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic [26:0] obs;
  int cmp_n = 0, err_n = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock_i(clk), .reset_i(reset), .opcode_i(opcode), .funct_i(funct),
    .mem_ready_i(mem_ready), .pc_write_o(pc_write), .branch_eq_o(branch_eq),
    .branch_ne_o(branch_ne), .pc_src_o(pc_src), .ior_d_o(ior_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .instr_done_o(instr_done), .illegal_o(illegal), .state_o(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, branch_eq, branch_ne, pc_src, ior_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done,
                illegal, state};

  function automatic logic [26:0] w(input int pcw, beq, bne, ps, iord, mr, mw, irw, rw, rd,
                                     m2r, asa, asb, aop, done, ill, st);
    return {1'(pcw), 1'(beq), 1'(bne), 2'(ps), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rw),
            2'(rd), 2'(m2r), 1'(asa), 3'(asb), 3'(aop), 1'(done), 1'(ill), 4'(st)};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input string tag, input logic [26:0] exp);
    @(negedge clk);
    reset = rst;
    mem_ready = rdy;
    #1;
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [26:0] f1, f0, dc, rz;
    f1 = w(1,0,0,0,0,1,0,1,0,0,0,0,1,0,0,0,0);
    f0 = w(0,0,0,0,0,1,0,0,0,0,0,0,1,0,0,0,0);
    dc = w(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0,1);
    rz = w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
    cyc(1, 1, "reset", rz);
    // lw, zero wait
    opcode = 6'd35;
    cyc(0, 1, "lw_fetch", f1);
    cyc(0, 1, "lw_decode", dc);
    cyc(0, 1, "lw_addr", w(0,0,0,0,0,0,0,0,0,0,0,1,2,0,0,0,2));
    cyc(0, 1, "lw_read", w(0,0,0,0,1,1,0,0,0,0,0,0,0,0,0,0,3));
    cyc(0, 1, "lw_wb", w(0,0,0,0,0,0,0,0,1,0,1,0,0,0,1,0,4));
    // sw with three wait cycles
    opcode = 6'd43;
    cyc(0, 1, "sw_fetch", f1);
    cyc(0, 1, "sw_decode", dc);
    cyc(0, 1, "sw_addr", w(0,0,0,0,0,0,0,0,0,0,0,1,2,0,0,0,2));
    for (int i = 0; i < 3; i++) cyc(0, 0, "sw_wait", w(0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0,5));
    cyc(0, 1, "sw_done", w(0,0,0,0,1,0,1,0,0,0,0,0,0,0,1,0,5));
    // R-type add
    opcode = 6'd0; funct = 6'd32;
    cyc(0, 1, "r_fetch", f1);
    cyc(0, 1, "r_decode", dc);
    cyc(0, 1, "r_exec", w(0,0,0,0,0,0,0,0,0,0,0,1,0,2,0,0,6));
    cyc(0, 1, "r_wb", w(0,0,0,0,0,0,0,0,1,1,0,0,0,0,1,0,7));
    // ori
    opcode = 6'd13;
    cyc(0, 1, "ori_fetch", f1);
    cyc(0, 1, "ori_decode", dc);
    cyc(0, 1, "ori_exec", w(0,0,0,0,0,0,0,0,0,0,0,1,4,3,0,0,9));
    cyc(0, 1, "ori_wb", w(0,0,0,0,0,0,0,0,1,0,0,0,0,0,1,0,7));
    // slti
    opcode = 6'd10;
    cyc(0, 1, "slti_fetch", f1);
    cyc(0, 1, "slti_decode", dc);
    cyc(0, 1, "slti_exec", w(0,0,0,0,0,0,0,0,0,0,0,1,2,6,0,0,9));
    cyc(0, 1, "slti_wb", w(0,0,0,0,0,0,0,0,1,0,0,0,0,0,1,0,7));
    // jr
    opcode = 6'd0; funct = 6'd8;
    cyc(0, 1, "jr_fetch", f1);
    cyc(0, 1, "jr_decode", dc);
    cyc(0, 1, "jr", w(1,0,0,3,0,0,0,0,0,0,0,0,0,0,1,0,11));
    // bne
    opcode = 6'd5; funct = 6'd0;
    cyc(0, 1, "bne_fetch", f1);
    cyc(0, 1, "bne_decode", dc);
    cyc(0, 1, "bne", w(0,0,1,1,0,0,0,0,0,0,0,1,0,1,1,0,8));
    // jal
    opcode = 6'd3;
    cyc(0, 1, "jal_fetch", f1);
    cyc(0, 1, "jal_decode", dc);
    cyc(0, 1, "jal", w(1,0,0,2,0,0,0,0,1,2,2,0,0,0,1,0,10));
    // lui
    opcode = 6'd15;
    cyc(0, 1, "lui_fetch", f1);
    cyc(0, 1, "lui_decode", dc);
    cyc(0, 1, "lui_wb", w(0,0,0,0,0,0,0,0,1,0,3,0,0,0,1,0,12));
    // reset abandons a lw in MEM_ADDR
    opcode = 6'd35;
    cyc(0, 1, "abort_fetch", f1);
    cyc(0, 1, "abort_decode", dc);
    cyc(1, 1, "abort_reset", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,2));
    cyc(0, 1, "abort_refetch", f1);
    // unknown opcode sticks in ILLEGAL until reset
    opcode = 6'd63;
    cyc(0, 1, "ill_decode", dc);
    cyc(0, 1, "ill_state", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,13));
    cyc(0, 1, "ill_sticky", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,13));
    cyc(1, 1, "ill_reset", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,13));
    cyc(0, 0, "ill_cleared", f0);
    // fetch timeout: that was wait cycle 1, three more then ILLEGAL
    for (int i = 0; i < 3; i++) cyc(0, 0, "to_wait", f0);
    cyc(0, 0, "to_illegal", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,13));
    cyc(0, 1, "to_sticky", w(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,13));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS core. It replaces the single-cycle decode with a Moore state machine, so one ALU, one unified memory port and the register file are reused across the steps of each instruction. The block sits beside the datapath registers (PC, IR, MDR, A, B, ALUOut). It drives every enable and mux select, and it waits on a memory ready handshake.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready before bus error; range 1..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- branch_eq, branch_ne  out  1 each  PC loads if ALU zero is 1 / 0 respectively.
- pc_src  out  2  next-PC source: 0 ALU result, 1 ALUOut, 2 jump address {PC[31:28],IR[25:0],2'b00}, 3 rs data.
- ior_d  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read, mem_write, ir_write, reg_write  out  1 each.
- reg_dst  out  2  destination register: 0 rt, 1 rd, 2 $31.
- mem_to_reg  out  2  write-back source: 0 ALUOut, 1 MDR, 2 PC, 3 {imm,16'b0}.
- alu_src_a  out  1  ALU A input: 0 PC, 1 A.
- alu_src_b  out  3  ALU B input: 0 B, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm<<2, 4 zero-extended imm.
- alu_op  out  3  to AluControlUint: 0 add, 1 sub, 2 funct, 3 or, 4 and, 5 xor, 6 slt.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  sticky; unknown opcode or memory timeout.
- state  out  4  current state, for debug.

## Operation
- Outputs are a Moore decode of state; any output not listed for a state is 0. Opcode and funct select variants only inside a state.
- FETCH (0): mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. When mem_ready=1, assert ir_write and pc_write and go to DECODE; otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=3, alu_op=0 (branch target goes into ALUOut). Next state by opcode:
  - 35 or 43 → MEM_ADDR.
  - 0 with funct 8 → JR.
  - 0 otherwise → R_EXEC.
  - 4 or 5 → BRANCH.
  - 8, 10, 12, 13, 14 → I_EXEC.
  - 15 → LUI_WB.
  - 2 or 3 → JUMP.
  - anything else → ILLEGAL.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): mem_read=1, ior_d=1. Go to MEM_WB on mem_ready.
- MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WRITE (5): mem_write=1, ior_d=1. Go to FETCH on mem_ready.
- R_EXEC (6): alu_src_a=1, alu_src_b=0, alu_op=2. Then ALU_WB.
- I_EXEC (9): alu_src_a=1.
  - alu_src_b: 2 for opcodes 8 and 10; 4 for 12, 13, 14.
  - alu_op: 0 for 8, 6 for 10, 4 for 12, 3 for 13, 5 for 14.
  - Then ALU_WB.
- ALU_WB (7): reg_write=1, mem_to_reg=0, reg_dst=1 if opcode=0, else 0. Then FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1. branch_eq=1 for opcode 4, branch_ne=1 for opcode 5. Then FETCH.
- JUMP (10): pc_src=2, pc_write=1. For opcode 3 also reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Then FETCH.
- JR (11): pc_src=3, pc_write=1. Then FETCH.
- LUI_WB (12): reg_write=1, reg_dst=0, mem_to_reg=3. Then FETCH.
- ILLEGAL (13): no enables asserted; illegal=1. Held until reset.
- Wait counter (8 bits):
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE, and whenever mem_ready=1.
  - Increments each cycle spent waiting.
  - If it reaches MEM_TIMEOUT while mem_ready=0, go to ILLEGAL next cycle.

## Timing
- Reset cycle: state←FETCH, counter←0, illegal←0.
  - While reset=1, force low: pc_write, branch_eq, branch_ne, mem_read, mem_write, ir_write, reg_write, instr_done.
  - All select outputs read 0.
- Reset mid-instruction abandons that instruction. No write is issued from the reset cycle onward. Fetch restarts the cycle after reset deasserts.
- Cycles per instruction with zero wait states:
  - lw 5.
  - sw, R-type, I-type 4.
  - beq/bne, j, jal, jr, lui 3.
- Each wait cycle adds 1.
- mem_read/mem_write, ior_d and the ALU selects stay stable throughout the wait.
- instr_done is high exactly in the cycle whose next state is FETCH. It is never high in ILLEGAL.

## Test plan
- lw with mem_ready tied to 1 → states 0,1,2,3,4. reg_write only in state 4, with mem_to_reg=1 and reg_dst=0. instr_done in cycle 5.
- sw with mem_ready low for 3 cycles in MEM_WRITE → mem_write=1, ior_d=1 held for 4 cycles. Exactly one instr_done. Total 7 cycles.
- opcode 0 with funct 8 (jr) → DECODE→JR. pc_src=3, pc_write=1, reg_write=0 throughout.
- bne (opcode 5) → BRANCH with branch_ne=1, branch_eq=0, alu_op=1. jal (opcode 3) → reg_dst=2, mem_to_reg=2, pc_src=2.
- opcode 63 → ILLEGAL, illegal=1 sticky. reset for one cycle → state 0 and illegal=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 → ILLEGAL after 4 wait cycles. ir_write never asserted.
